// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the word-wide data memory.
// Optional: define DMEM_ALIGN_CHECK_EN to reject addresses with addr[1:0] != 0.
module dmem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nx;
    logic              last_gnt;
    logic              can_acc, gnt0, gnt1, accept;
    logic              l_port, l_we, l_err;
    logic              sel_we, sel_err, range_err;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [DATA_W-1:0] rd_val;
    logic              in_access;

    // ready is gated by rst_n so nothing is offered while held in reset
    assign can_acc    = rst_n & ((state == IDLE) | (state == RESP));
    assign gnt0       = can_acc & req0_valid & (~req1_valid | last_gnt);
    assign gnt1       = can_acc & req1_valid & (~req0_valid | ~last_gnt);
    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign accept     = gnt0 | gnt1;

    assign sel_we    = gnt1 ? req1_we    : req0_we;
    assign sel_addr  = gnt1 ? req1_addr  : req0_addr;
    assign sel_wdata = gnt1 ? req1_wdata : req0_wdata;

    // widened by one bit so addresses near the top cannot wrap past the check
    assign range_err = ({1'b0, sel_addr} + (ADDR_W+1)'(3))
                       >= (ADDR_W+1)'(MEM_BYTES);

`ifdef DMEM_ALIGN_CHECK_EN
    assign sel_err = range_err | (sel_addr[1:0] != 2'b00);
`else
    assign sel_err = range_err;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? ACCESS : IDLE;
            ACCESS:  state_nx = RESP;
            RESP:    state_nx = accept ? ACCESS : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_access = (state == ACCESS);
    assign rd_val    = (~l_we & ~l_err) ? mem_rd : '0;

    always_comb begin
        mem_we = in_access & l_we & ~l_err & rst_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_gnt   <= 1'b1;
            l_port     <= 1'b0;
            l_we       <= 1'b0;
            l_err      <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            rsp0_valid <= 1'b0;
            rsp0_rdata <= '0;
            rsp0_err   <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp1_rdata <= '0;
            rsp1_err   <= 1'b0;
        end else begin
            if (accept) begin
                last_gnt <= gnt1;
                l_port   <= gnt1;
                l_we     <= sel_we;
                l_err    <= sel_err;
                mem_addr <= sel_addr;
                mem_wd   <= sel_wdata;
            end
            rsp0_valid <= in_access & ~l_port;
            rsp0_rdata <= (in_access & ~l_port) ? rd_val : '0;
            rsp0_err   <= in_access & ~l_port & l_err;
            rsp1_valid <= in_access & l_port;
            rsp1_rdata <= (in_access & l_port) ? rd_val : '0;
            rsp1_err   <= in_access & l_port & l_err;
        end
    end

endmodule
